// File: rtl/alu_pkg.sv
// Shared types for the ALU / multiply-divide block.
//   XLEN_DEFAULT : default operand width
//   alu_op_e     : opcode encoding on the op port
//   state_e      : control FSM states of alu_md
//   is_muldiv()  : true for the iterative opcodes 16-23
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OP_W         = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_XOR    = 5'd3,
    OP_SRL    = 5'd4,
    OP_SRA    = 5'd5,
    OP_OR     = 5'd6,
    OP_AND    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Opcodes 16..23 share the 0b10xxx prefix.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider, one bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   flush      : abort any running operation
//   start      : load operands and begin (sel = op[2:0] of opcodes 16-23)
//   a, b       : operands
//   done_c     : high during the last iteration cycle
//   res_c      : final result, valid while done_c is high
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done_c,
  output logic [XLEN-1:0] res_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            running;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;   // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] dsor;     // multiplicand or divisor magnitude
  logic [2:0]      sel_q;
  logic            neg_q;    // negate product / quotient
  logic            neg_rem_q;
  logic            dz_q;
  logic [XLEN-1:0] a_q;

  // Operand sign handling: signed operands are converted to magnitudes.
  logic a_signed, b_signed, a_neg, b_neg;
  always_comb begin
    a_signed = (sel == 3'd1) || (sel == 3'd2) || (sel == 3'd4) || (sel == 3'd6);
    b_signed = (sel == 3'd1) || (sel == 3'd4) || (sel == 3'd6);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
  end

  // One iteration step, shared datapath registers for both algorithms.
  logic [XLEN:0]     mul_sum, r_sh, diff;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dsor} : '0);
    r_sh    = {acc_hi, acc_lo[XLEN-1]};
    diff    = r_sh - {1'b0, dsor};
    hi_n    = mul_sum[XLEN:1];
    lo_n    = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (sel_q[2]) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = r_sh[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
  end

  // Result select with sign fix-up and divide-by-zero override.
  always_comb begin
    done_c = running && (cnt == CW'(XLEN-1));
    case (sel_q)
      3'd0:       res_c = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       res_c = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: res_c = dz_q ? '1 : (neg_q ? -lo_n : lo_n);
      default:    res_c = dz_q ? a_q : (neg_rem_q ? -hi_n : hi_n);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      dsor      <= '0;
      sel_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
    end else if (flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running   <= 1'b1;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= a_neg ? -a : a;
      dsor      <= b_neg ? -b : b;
      sel_q     <= sel;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= (b == '0);
      a_q       <= a;
    end else if (running) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      if (done_c) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// Integer ALU with iterative multiply/divide and valid/ready handshakes.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous abort of in-flight or held operation
//   in_valid, in_ready  : request handshake; op, a, b captured on transfer
//   out_valid, out_ready: result handshake; result held while stalled
//   busy                : iterative multiply/divide in progress
module alu_md
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e          state;
  logic            init_done;  // gates in_ready until the first edge after reset
  logic            accept;
  logic            md_op;
  logic [XLEN-1:0] alu_c;
  logic            md_done_c;
  logic [XLEN-1:0] md_res_c;

  always_comb begin
    in_ready = init_done && (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    accept   = in_valid && in_ready;
    md_op    = is_muldiv(op);
  end

  // Single-cycle operations; unknown opcodes yield zero.
  always_comb begin
    alu_c = '0;
    case (op)
      OP_ADD:  alu_c = a + b;
      OP_SUB:  alu_c = a - b;
      OP_SLL:  alu_c = a << b[SHW-1:0];
      OP_XOR:  alu_c = a ^ b;
      OP_SRL:  alu_c = a >> b[SHW-1:0];
      OP_SRA:  alu_c = XLEN'($signed(a) >>> b[SHW-1:0]);
      OP_OR:   alu_c = a | b;
      OP_AND:  alu_c = a & b;
      OP_SLT:  alu_c = XLEN'($signed(a) < $signed(b));
      OP_SLTU: alu_c = XLEN'(a < b);
      default: alu_c = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept && md_op),
    .sel    (op[2:0]),
    .a      (a),
    .b      (b),
    .done_c (md_done_c),
    .res_c  (md_res_c)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (flush) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
              if (md_op) begin
                state <= op[2] ? S_DIV : S_MUL;
                busy  <= 1'b1;
              end else begin
                result    <= alu_c;
                out_valid <= 1'b1;
              end
            end
          end
          S_MUL, S_DIV: begin
            if (md_done_c) begin
              result    <= md_res_c;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (XLEN = 32).
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_md #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for its result, check value, latency and busy cycles.
  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bc;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    bc  = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (out_valid) break;
    end
    chk({tag, "/res"}, result, exp);
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) chk({tag, "/busy"}, 32'(bc), 32'(exp_lat - 1));
  endtask

  initial begin
    int ov_seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst/in_ready", 32'(in_ready), 32'd0);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/result", result, 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst/ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst/ready_after_edge", 32'(in_ready), 32'd1);

    // Single-cycle ops
    do_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
    do_op("slt",     5'd8, 32'h8000_0000, 32'h1, 32'h1, 1);
    do_op("sltu",    5'd9, 32'h8000_0000, 32'h1, 32'h0, 1);
    do_op("sra",     5'd5, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
    do_op("sll",     5'd2, 32'h1, 32'd31, 32'h8000_0000, 1);
    do_op("srl",     5'd4, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    do_op("sub_wrap", 5'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
    do_op("xor",     5'd3, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1);
    do_op("bad_op",  5'd12, 32'h1234_5678, 32'h1, 32'h0, 1);

    // Back-to-back issue
    @(negedge clk);
    op = 5'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 op = 5'd6; a = 32'hF0; b = 32'h0F;
    @(negedge clk);
    chk("b2b/first", result, 32'd3);
    chk("b2b/ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b/second", result, 32'hFF);
    chk("b2b/valid", 32'(out_valid), 32'd1);

    // Multiply
    do_op("mulh",   5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    do_op("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mul",    5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
    do_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("mul2",   5'd16, 32'd12345, 32'd6789, 32'd83810205, 33);

    // Divide
    do_op("div_z",   5'd20, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    do_op("rem_z",   5'd22, 32'd7, 32'd0, 32'd7, 33);
    do_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    do_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    do_op("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("divu",    5'd21, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu",    5'd23, 32'd100, 32'd7, 32'd2, 33);

    // Backpressure: hold out_ready low for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    op = 5'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold/result", result, 32'd11);
      chk("hold/valid", 32'(out_valid), 32'd1);
      chk("hold/in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold/released_valid", 32'(out_valid), 32'd0);
    chk("hold/released_ready", 32'(in_ready), 32'd1);

    // Flush at cycle 10 of a DIVU
    @(negedge clk);
    op = 5'd21; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush/busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    #1 chk("flush/in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush/busy_after", 32'(busy), 32'd0);
    chk("flush/idle_ready", 32'(in_ready), 32'd1);
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("flush/no_result", 32'(ov_seen), 32'd0);
    do_op("flush/add", 5'd0, 32'd2, 32'd3, 32'd5, 1);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 5'd16; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst/busy", 32'(busy), 32'd0);
    chk("mrst/result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("mrst/no_result", 32'(ov_seen), 32'd0);
    do_op("mrst/add", 5'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
